hd_timing_gen: RTL and testbench
================================

HD_TIMING_GEN -- requirements
Module: hd_timing_gen

Interface
REQ-001 CLK  input  1  master clock; all state changes on rising edge.
REQ-002 CLR  input  1  reset, asynchronous, active-high.
REQ-003 QD  input  1  start pushbutton, asynchronous level; only rising edges are used.
REQ-004 STOP  input  1  controller stop request, combinational, valid during T3.
REQ-005 SHORT  input  1  controller request to end the instruction after W1, valid during T3.
REQ-006 LONG  input  1  controller request to add beat W3 after W2, valid during T3.
REQ-007 T  output  3  one-hot phase {T3,T2,T1} while running; 000 while halted.
REQ-008 W  output  3  one-hot beat {W3,W2,W1}; always exactly one bit set.
REQ-009 RUNNING  output  1  1 in RUN state, 0 in HALT.
REQ-010 BEATCNT  output  8  count of completed beats, wraps modulo 256.

Function
REQ-011 Two states: HALT and RUN; all outputs registered.
REQ-012 QD passes through a 2-flop synchronizer plus a third flop; start pulse = sync2 & !sync3.
REQ-013 In HALT, a start pulse moves the block to RUN with T=001 on the next edge; total latency is 3 edges from the first edge sampling QD high.
REQ-014 QD held high produces exactly one start; QD edges during RUN are discarded, not queued.
REQ-015 In RUN, T advances T1->T2->T3->T1, one phase per clock.
REQ-016 Beat decision is made on the edge that ends T3, using STOP/SHORT/LONG sampled on that edge.
REQ-017 From W1: SHORT=1 -> next W1; else -> W2; LONG is ignored in W1.
REQ-018 From W2: LONG=1 -> next W3; else -> W1; SHORT is ignored in W2.
REQ-019 From W3: always -> W1; SHORT and LONG are ignored.
REQ-020 SHORT=1 and LONG=1 together in W1: SHORT wins.
REQ-021 On the same T3-ending edge, BEATCNT increments by 1 (255->0).
REQ-022 STOP=1 on the T3-ending edge: W still updates per REQ-017..019, BEATCNT still increments, the state goes to HALT, and T becomes 000.
REQ-023 After a STOP, the next start resumes at T1 of the already-updated W (e.g. stop in W2 with LONG resumes in W3).
REQ-024 STOP/SHORT/LONG sampled outside T3 have no effect.
REQ-025 In HALT, W and BEATCNT hold their values.

Reset
REQ-026 CLR=1 forces immediately, independent of CLK: HALT, T=000, W=001, RUNNING=0, BEATCNT=0, synchronizer flops=0.
REQ-027 CLR asserted mid-beat aborts the beat; no partial update survives.
REQ-028 After CLR deasserts, a new QD rising edge is required to start.
REQ-029 A QD level already high at CLR release produces no start until QD goes low and high again.

Verification
REQ-030 Start: reset, QD 0->1 held for 10 clocks -> T=001 on the 3rd edge after QD is sampled, RUNNING=1, and exactly one start occurs.
REQ-031 Normal instruction (SHORT=0, LONG=0, STOP=0) -> W sequence 001,010,001; BEATCNT +2 per instruction; each beat lasts 3 clocks.
REQ-032 Long instruction: LONG=1 during W2 T3 -> W 001,010,100,001; LONG=1 during W1 T3 -> no W3 is entered.
REQ-033 STOP during W2 with LONG=1 -> T=000, W=100, RUNNING=0, BEATCNT incremented; next QD -> resumes with T=001, W=100.
REQ-034 Wrap and reset: run 256 beats -> BEATCNT=0; assert CLR during T2 -> all outputs reach reset values immediately, before any clock edge.

Source files
------------

// File: rtl/hd_timing_gen.sv
// hd_timing_gen: instruction timing generator. Produces a one-hot phase
// T (T1..T3) and a one-hot beat W (W1..W3) for a simple controller.
// The controller steers beat sequencing (SHORT/LONG) and can halt the
// machine (STOP) at the end of any beat. A pushbutton (QD) restarts it.
module hd_timing_gen (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       QD,
  input  logic       STOP,
  input  logic       SHORT,
  input  logic       LONG,
  output logic [2:0] T,
  output logic [2:0] W,
  output logic       RUNNING,
  output logic [7:0] BEATCNT
);

  typedef enum logic {S_HALT = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [2:0] PH_NONE = 3'b000;
  localparam logic [2:0] PH_T1   = 3'b001;
  localparam logic [2:0] PH_T2   = 3'b010;
  localparam logic [2:0] PH_T3   = 3'b100;
  localparam logic [2:0] BT_W1   = 3'b001;
  localparam logic [2:0] BT_W2   = 3'b010;
  localparam logic [2:0] BT_W3   = 3'b100;

  state_t state;

  // Synchronizer chain and the edge detector built on it.
  logic sync1, sync2, sync3;
  // fill1/fill2 mark when sync2 holds a genuine QD sample (not the reset 0).
  logic fill1, fill2;
  // armed goes high once QD has been seen low after reset, so a level that
  // was already high at reset release cannot masquerade as a rising edge.
  logic armed;
  logic start;

  assign start   = sync2 & ~sync3 & armed;
  assign RUNNING = (state == S_RUN);

  // Beat successor chosen at the end of T3.
  function automatic logic [2:0] next_beat(input logic [2:0] cur,
                                           input logic       short_req,
                                           input logic       long_req);
    case (cur)
      BT_W1:   next_beat = short_req ? BT_W1 : BT_W2;
      BT_W2:   next_beat = long_req  ? BT_W3 : BT_W1;
      default: next_beat = BT_W1;
    endcase
  endfunction

  // Bring QD into the clock domain and arm edge detection after reset.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      fill1 <= 1'b0;
      fill2 <= 1'b0;
      armed <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of its source, which is what turns these lines into a chain.
      sync1 <= QD;
      sync2 <= sync1;
      sync3 <= sync2;
      fill1 <= 1'b1;
      fill2 <= fill1;
      if (fill2 && !sync2) armed <= 1'b1;
    end
  end

  // HALT/RUN machine with phase, beat and beat counter all registered.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state   <= S_HALT;
      T       <= PH_NONE;
      W       <= BT_W1;
      BEATCNT <= 8'd0;
    end else begin
      case (state)
        S_HALT: begin
          if (start) begin
            state <= S_RUN;
            T     <= PH_T1;
          end
        end
        S_RUN: begin
          case (T)
            PH_T1: T <= PH_T2;
            PH_T2: T <= PH_T3;
            PH_T3: begin
              W       <= next_beat(W, SHORT, LONG);
              BEATCNT <= BEATCNT + 8'd1;
              if (STOP) begin
                state <= S_HALT;
                T     <= PH_NONE;
              end else begin
                T <= PH_T1;
              end
            end
            default: T <= PH_T1;
          endcase
        end
        default: begin
          state <= S_HALT;
          T     <= PH_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hd_timing_gen.sv
// Testbench for hd_timing_gen: directed scenarios with literal expectations
// followed by a long randomized run, all compared every cycle against a
// behavioural model of phases, beats and start detection.
module tb_hd_timing_gen;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       QD;
  logic       STOP;
  logic       SHORT;
  logic       LONG;
  logic [2:0] T;
  logic [2:0] W;
  logic       RUNNING;
  logic [7:0] BEATCNT;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  hd_timing_gen dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .QD      (QD),
    .STOP    (STOP),
    .SHORT   (SHORT),
    .LONG    (LONG),
    .T       (T),
    .W       (W),
    .RUNNING (RUNNING),
    .BEATCNT (BEATCNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase: 0..2 = T1..T3, m_beat: 0..2 = W1..W3.
  bit m_run   = 1'b0;
  int m_phase = 0;
  int m_beat  = 0;
  int m_cnt   = 0;
  bit m_prev  = 1'b1;  // level at reset release is treated as already high
  bit m_d1    = 1'b0;  // start-to-action latency queue (2 edges)
  bit m_d2    = 1'b0;

  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      m_run = 0; m_phase = 0; m_beat = 0; m_cnt = 0;
      m_prev = 1; m_d1 = 0; m_d2 = 0;
    end else begin
      bit eff;
      bit rise;
      eff  = m_d2;
      m_d2 = m_d1;
      rise = QD && !m_prev;
      m_prev = QD;
      m_d1 = rise;
      if (!m_run) begin
        if (eff) begin
          m_run = 1;
          m_phase = 0;
        end
      end else if (m_phase < 2) begin
        m_phase++;
      end else begin
        case (m_beat)
          0:       m_beat = SHORT ? 0 : 1;
          1:       m_beat = LONG ? 2 : 0;
          default: m_beat = 0;
        endcase
        m_cnt = (m_cnt + 1) % 256;
        if (STOP) m_run = 0;
        else      m_phase = 0;
      end
    end
  end

  // Compare DUT against model on every falling edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      check("model_T",       {29'd0, T},       m_run ? (32'd1 << m_phase) : 32'd0);
      check("model_W",       {29'd0, W},       32'd1 << m_beat);
      check("model_RUNNING", {31'd0, RUNNING}, {31'd0, m_run});
      check("model_BEATCNT", {24'd0, BEATCNT}, m_cnt);
    end
  end

  // Advance n rising edges and settle just after the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int hold;
    CLR = 1'b1; QD = 1'b0; STOP = 1'b0; SHORT = 1'b0; LONG = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_T",       {29'd0, T},       0);
    check("reset_W",       {29'd0, W},       1);
    check("reset_RUNNING", {31'd0, RUNNING}, 0);
    check("reset_BEATCNT", {24'd0, BEATCNT}, 0);
    CLR = 1'b0;
    cmp_en = 1'b1;

    // Start: QD rises, T=001 on the third edge after it is sampled.
    repeat (3) @(negedge CLK);
    QD = 1'b1;
    edges(2);
    check("start_lat_T", {29'd0, T}, 0);
    edges(1);
    check("start_T",       {29'd0, T},       1);
    check("start_RUNNING", {31'd0, RUNNING}, 1);
    check("start_W",       {29'd0, W},       1);

    // Normal instruction: W1 -> W2 -> W1, three clocks per beat.
    edges(3);
    check("norm_W2",  {29'd0, W},       2);
    check("norm_cnt1",{24'd0, BEATCNT}, 1);
    edges(3);
    check("norm_W1",  {29'd0, W},       1);
    check("norm_cnt2",{24'd0, BEATCNT}, 2);

    // Long instruction: LONG held through W1 (ignored) and W2 (adds W3).
    LONG = 1'b1;
    edges(3);
    check("long_W2", {29'd0, W}, 2);
    edges(3);
    check("long_W3", {29'd0, W}, 4);
    LONG = 1'b0;
    edges(3);
    check("long_W1",  {29'd0, W},       1);
    check("long_cnt", {24'd0, BEATCNT}, 5);

    // Short instruction: stays in W1.
    SHORT = 1'b1;
    edges(3);
    check("short_W1",  {29'd0, W},       1);
    check("short_cnt", {24'd0, BEATCNT}, 6);
    SHORT = 1'b0;

    // STOP in W2 with LONG: halts with W already advanced to W3.
    edges(3);
    check("pre_stop_W2", {29'd0, W}, 2);
    STOP = 1'b1; LONG = 1'b1;
    edges(3);
    check("stop_T",       {29'd0, T},       0);
    check("stop_W",       {29'd0, W},       4);
    check("stop_RUNNING", {31'd0, RUNNING}, 0);
    check("stop_cnt",     {24'd0, BEATCNT}, 8);
    STOP = 1'b0; LONG = 1'b0;

    // QD still held high from the first press: no second start.
    edges(8);
    check("held_no_start", {31'd0, RUNNING}, 0);

    // New press resumes in W3 at T1.
    @(negedge CLK) QD = 1'b0;
    repeat (3) @(negedge CLK);
    QD = 1'b1;
    edges(2);
    check("resume_lat_T", {29'd0, T}, 0);
    edges(1);
    check("resume_T",       {29'd0, T},       1);
    check("resume_W",       {29'd0, W},       4);
    check("resume_RUNNING", {31'd0, RUNNING}, 1);
    edges(3);
    check("resume_next_W", {29'd0, W},       1);
    check("resume_cnt",    {24'd0, BEATCNT}, 9);

    // Counter wrap: 247 more beats bring it from 9 to 0.
    edges(3 * 247);
    check("wrap_cnt", {24'd0, BEATCNT}, 0);
    check("wrap_W",   {29'd0, W},       2);
    check("wrap_T",   {29'd0, T},       1);

    // CLR during T2 takes effect before the next clock edge.
    edges(1);
    check("pre_clr_T2", {29'd0, T}, 2);
    #2 CLR = 1'b1;
    #1;
    check("clr_T",       {29'd0, T},       0);
    check("clr_W",       {29'd0, W},       1);
    check("clr_RUNNING", {31'd0, RUNNING}, 0);
    check("clr_BEATCNT", {24'd0, BEATCNT}, 0);
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b0;

    // QD high at CLR release must not start the machine.
    edges(6);
    check("clr_release_no_start", {31'd0, RUNNING}, 0);

    // Randomized run; QD levels are held at least 4 clocks.
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      STOP  = ($urandom_range(0, 9) == 0);
      SHORT = $urandom_range(0, 1);
      LONG  = $urandom_range(0, 1);
      hold++;
      if (hold >= 4 && $urandom_range(0, 5) == 0) begin
        QD = ~QD;
        hold = 0;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        hold = 0;
      end
    end

    @(negedge CLK);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
